// File: rtl/logic_op_pipe.sv
// rtl/logic_op_pipe.sv - two-stage pipelined bitwise logic unit with accumulator and result counter
//
// Purpose: WIDTH-bit bitwise logic unit. Operand beats enter through a
// valid/ready handshake, are captured in stage S1, evaluated into stage S2
// and leave through a valid/ready handshake with backpressure.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (combinational, depends on out_ready)
//   a, b       WIDTH-bit operands
//   op         3-bit operation select, sampled with a and b
//   acc_clr    synchronous clear of the internal accumulator
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   y          WIDTH-bit result
//   y_parity   XOR-reduction of y, registered with y
//   y_zero     1 when y == 0, registered with y
//   op_count   number of results consumed, wraps modulo 2^CNT_W
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_parity,
  output logic             y_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_CMPD = 3'd6;
  localparam logic [2:0] OP_ACC  = 3'd7;

  // Stage S1
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  // Stage S2
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_y_parity;
  logic             r_y_zero;

  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_free;
  logic             w_move;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_result;

  assign w_s2_free  = !r_out_valid || out_ready;
  assign w_move     = r_s1_valid && w_s2_free;
  assign in_ready   = !reset && (!r_s1_valid || w_s2_free);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // A clear coinciding with an ACC move takes effect before the fold-in.
  assign w_acc_base = acc_clr ? '0 : r_acc;
  assign w_acc_next = w_acc_base ^ r_s1_a ^ r_s1_b;

  always_comb begin
    w_result = '0;
    case (r_s1_op)
      OP_AND:  w_result = r_s1_a & r_s1_b;
      OP_OR:   w_result = r_s1_a | r_s1_b;
      OP_NAND: w_result = ~(r_s1_a & r_s1_b);
      OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
      OP_XOR:  w_result = r_s1_a ^ r_s1_b;
      OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
      // Compound gate kept in its original form; it reduces to all ones.
      OP_CMPD: w_result = ~((r_s1_a ^ r_s1_b) & ~(~r_s1_a | ~r_s1_b));
      OP_ACC:  w_result = w_acc_next;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= op;
    end else if (w_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_parity  <= 1'b0;
      r_y_zero    <= 1'b1;
    end else if (w_move) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_y_parity  <= ^w_result;
      r_y_zero    <= (w_result == '0);
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_move && (r_s1_op == OP_ACC)) begin
      r_acc <= w_acc_next;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_count <= '0;
    end else if (w_out_xfer) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_parity  = r_y_parity;
  assign y_zero    = r_y_zero;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb/tb_logic_op_pipe.sv - self-checking bench for logic_op_pipe
module tb_logic_op_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, y_parity, y_zero;
  logic [7:0]  y;
  logic [15:0] op_count;

  logic        in_ready2, out_valid2, y_parity2, y_zero2;
  logic [7:0]  y2;
  logic [1:0]  op_count2;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .y_parity(y_parity), .y_zero(y_zero), .op_count(op_count)
  );

  logic_op_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
    .y_parity(y_parity2), .y_zero(y_zero2), .op_count(op_count2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats waiting in S1 and the currently presented result.
  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [2:0] op; } beat_t;
  typedef struct packed { logic [7:0] y; logic p; logic z; } res_t;
  typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] ey; logic ep; logic ez; } vec_t;

  beat_t      q[$];
  res_t       tq[$];
  logic       mv = 1'b0;
  logic [7:0] my = '0;
  logic       mpar = 1'b0;
  logic       mzero = 1'b1;
  logic [7:0] macc = '0;
  int         mcnt = 0;

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x,
                                        input logic [7:0] z, input logic [7:0] acc);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~((x ^ z) & ~(~x | ~z));
      default: return acc ^ x ^ z;
    endcase
  endfunction

  // Inputs are set at the falling edge; this checks, advances the model
  // across the next rising edge, and returns at the following falling edge.
  task automatic tick();
    logic  e_rdy, ox, free, mvv, ix;
    beat_t bt;
    logic [7:0] r;
    #1;
    e_rdy = !rst && (q.size() == 0 || !mv || out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
    chk("y", {24'd0, y}, {24'd0, my});
    chk("y_parity", {31'd0, y_parity}, {31'd0, mpar});
    chk("y_zero", {31'd0, y_zero}, {31'd0, mzero});
    chk("op_count", {16'd0, op_count}, mcnt & 32'hFFFF);
    chk("op_count2", {30'd0, op_count2}, mcnt & 32'h3);
    if (!rst && mv && out_ready && tq.size() > 0) begin
      chk("tbl_y", {24'd0, y}, {24'd0, tq[0].y});
      chk("tbl_par", {31'd0, y_parity}, {31'd0, tq[0].p});
      chk("tbl_zero", {31'd0, y_zero}, {31'd0, tq[0].z});
      void'(tq.pop_front());
    end
    if (rst) begin
      q.delete();
      mv = 1'b0; my = '0; mpar = 1'b0; mzero = 1'b1; macc = '0; mcnt = 0;
    end else begin
      ox   = mv && out_ready;
      free = !mv || out_ready;
      mvv  = q.size() > 0 && free;
      ix   = in_valid && e_rdy;
      if (acc_clr) macc = '0;
      if (mvv) begin
        bt = q.pop_front();
        r = ref_op(bt.op, bt.a, bt.b, macc);
        if (bt.op == 3'd7) macc = r;
        my = r; mpar = ^r; mzero = (r == 8'h00); mv = 1'b1;
      end else if (ox) begin
        mv = 1'b0;
      end
      if (ox) mcnt++;
      if (ix) q.push_back('{a: a, b: b, op: op});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    in_valid = 1'b1; op = o; a = x; b = z;
  endtask

  vec_t tbl[14];
  int   cnt0;
  logic [1:0] wrap_exp [5];

  initial begin
    tbl[0]  = '{3'd0, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{3'd1, 8'hC5, 8'h3A, 8'hFF, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 8'hC5, 8'h3A, 8'hFF, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{3'd4, 8'hC5, 8'h3A, 8'hFF, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 8'hC5, 8'h3A, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{3'd6, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[7]  = '{3'd6, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[8]  = '{3'd6, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[9]  = '{3'd6, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{3'd6, 8'h5A, 8'h0F, 8'hFF, 1'b0, 1'b0};
    tbl[11] = '{3'd7, 8'h0F, 8'h00, 8'h0F, 1'b0, 1'b0};
    tbl[12] = '{3'd7, 8'hF0, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[13] = '{3'd7, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Basic ops, CMPD and accumulator vectors, back-to-back.
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      tq.push_back('{y: tbl[i].ey, p: tbl[i].ep, z: tbl[i].ez});
      tick();
      if (i == 1) chk("latency_first", {31'd0, out_valid}, 32'd1);
      if (i == 5) chk("basic_count", {16'd0, op_count}, 32'd4);
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("table_count", {16'd0, op_count}, 32'd14);
    chk("table_drained", tq.size(), 32'd0);

    // Accumulator clear coinciding with an ACC move.
    send(3'd7, 8'h01, 8'h00); tq.push_back('{y: 8'h01, p: 1'b1, z: 1'b0}); tick();
    send(3'd7, 8'h11, 8'h22); tq.push_back('{y: 8'h33, p: 1'b0, z: 1'b0}); tick();
    in_valid = 1'b0; acc_clr = 1'b1; tick();
    acc_clr = 1'b0;
    #1 chk("acc_clr_y", {24'd0, y}, 32'h33);
    tick(); tick();

    // Backpressure: two beats fit, the third waits.
    cnt0 = mcnt;
    out_ready = 1'b0;
    send(3'd4, 8'h12, 8'h34); tq.push_back('{y: 8'h26, p: 1'b1, z: 1'b0}); tick();
    send(3'd4, 8'h55, 8'h0F); tq.push_back('{y: 8'h5A, p: 1'b0, z: 1'b0}); tick();
    send(3'd4, 8'h80, 8'h01); tq.push_back('{y: 8'h81, p: 1'b0, z: 1'b0});
    #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("bp_hold_y", {24'd0, y}, 32'h26);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("bp_count", {16'd0, op_count}, cnt0 + 3);
    chk("bp_drained", tq.size(), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(3'd1, 8'hAA, 8'h01); tick();
    send(3'd1, 8'hBB, 8'h02); tick();
    in_valid = 1'b0;
    rst = 1'b1; tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_y_zero", {31'd0, y_zero}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    send(3'd0, 8'hF0, 8'h3C); tq.push_back('{y: 8'h30, p: 1'b0, z: 1'b0}); tick();
    in_valid = 1'b0; tick(); tick();
    chk("post_rst_count", {16'd0, op_count}, 32'd1);

    // Counter wrap on the CNT_W=2 instance.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(3'd5, 8'(k), 8'h0F); tick();
      in_valid = 1'b0; tick(); tick();
      chk("wrap_count", {30'd0, op_count2}, {30'd0, wrap_exp[k]});
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc_clr   = ($urandom_range(0, 7) == 0);
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; generalises the 1-bit gate-level compound function (NAND of XOR and NOR-of-inverted-inputs) to WIDTH-bit operands.
- Adds an 8-entry operation select, a running XOR accumulator, and a completed-operation counter.
- Operands enter through a valid/ready input handshake, pass through a two-stage pipeline, and leave through a valid/ready output handshake with backpressure.
- Used as the shared logic datapath for the lab ALU exercises.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of op_count (>=1).

Ports:
- clk  in  1  Clock. All state changes on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- in_valid  in  1  Operand beat valid.
- in_ready  out  1  Block can accept an operand beat.
- a  in  WIDTH  Operand A.
- b  in  WIDTH  Operand B.
- op  in  3  Operation select, sampled with a and b.
- acc_clr  in  1  Synchronous clear of the accumulator.
- out_valid  out  1  Result valid.
- out_ready  in  1  Downstream accepts the result.
- y  out  WIDTH  Result.
- y_parity  out  1  XOR-reduction of y (registered with y).
- y_zero  out  1  1 when y == 0 (registered with y).
- op_count  out  CNT_W  Number of results consumed.

Behaviour:
- Op encoding (bitwise over WIDTH):
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 CMPD: y = ~((a^b) & ~(~a | ~b)).
  - 7 ACC: acc_next = acc ^ a ^ b; y = acc_next.
- Transfers:
  - Input transfer occurs on a clock edge where in_valid && in_ready.
  - Output transfer occurs on a clock edge where out_valid && out_ready.
- Stage S1 registers a, b, op and s1_valid.
  - S1 loads on an input transfer.
  - s1_valid clears when S1 moves to S2 and no new beat enters.
- Stage S2 registers y, y_parity, y_zero and out_valid, computed from the S1 contents.
  - Let s2_free = !out_valid || out_ready.
  - S1 moves to S2 when s1_valid && s2_free.
  - out_valid clears on an output transfer with no S1 beat moving in.
- in_ready = !reset && (!s1_valid || s2_free). Combinational; depends on out_ready.
- Latency and throughput:
  - A beat accepted at edge N shows out_valid=1 after edge N+1.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, y, y_parity, y_zero and out_valid hold stable.
  - S1 holds its beat; in_ready=0 when S1 is also full.
- Accumulator:
  - acc is WIDTH bits, internal only.
  - acc updates only when an op=7 beat moves S1 to S2.
  - acc_clr=1 clears acc on that edge.
  - If acc_clr coincides with an op=7 move, the clear applies first: acc and y become a^b.
  - acc_clr never affects S1, S2 or the valids.
- op_count increments by 1 on each output transfer and wraps modulo 2^CNT_W (all-ones to 0).
- Reset, including mid-operation:
  - s1_valid=0, out_valid=0, y=0, y_parity=0, y_zero=1, acc=0, op_count=0, in_ready=0.
  - Any beats in flight are discarded; no output transfer is counted on a reset edge.
- Inputs a, b and op are don't-care when in_valid=0.
- A change of op between beats never affects a beat already accepted.

Test Plan:
- Basic ops and latency:
  - Stimulus: WIDTH=8, out_ready=1; send a=0xC5, b=0x3A with op=0..5 on consecutive cycles.
  - Required: y = 0x00, 0xFF, 0xFF, 0x00, 0xFF, 0x00, each 2 cycles after acceptance, back-to-back; op_count=6.
- CMPD exhaustive:
  - Stimulus: op=6, all four 1-bit combinations replicated across the byte (0x00/0x00, 0x00/0xFF, 0xFF/0x00, 0xFF/0xFF), then a=0x5A, b=0x0F.
  - Required: y=0xFF, y_parity=0, y_zero=0 for every beat.
- Accumulator:
  - Stimulus: op=7 with (0x0F,0x00), then (0xF0,0x00), then (0x00,0xFF).
  - Required: y = 0x0F, 0xFF, 0x00 (last with y_zero=1).
  - Then acc_clr=1 in the same cycle as a (0x11,0x22) op=7 move: required y=0x33.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer 3 beats.
  - Required: 2 accepted, then in_ready=0; y stays at beat-1 value.
  - Release out_ready: required 3 results in order, no loss or duplication, op_count +3.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle with both stages full.
  - Required: out_valid=0, y=0, y_zero=1, op_count=0, in_ready=0 during reset; the next beat is processed normally.
- Counter wrap:
  - Stimulus: CNT_W=2, consume 5 results.
  - Required: op_count sequence 1, 2, 3, 0, 1.
